// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver.
// Combinational content only; no latency.
// No flow control.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF = 4'hF;

    // Active-low {g,f,e,d,c,b,a} patterns, entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        return SEG_LUT[nib];
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load channel from the core into the display driver.
// Pure wiring; no latency.
// valid/ready: a word transfers on a cycle where both are high.
interface seg7_scan_driver_if;
    import seg7_pkg::*;

    logic [4*NUM_DIGITS-1:0] load_data;
    logic [NUM_DIGITS-1:0]   load_dp;
    logic                    load_valid;
    logic                    load_ready;

    modport master (output load_data, output load_dp, output load_valid, input load_ready);
    modport slave  (input load_data, input load_dp, input load_valid, output load_ready);

endinterface

// File: rtl/hex_to_seg7.sv
// Hex nibble to active-low seven-segment pattern.
// Combinational, zero latency.
// No flow control.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_decode(nib_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Scans a double-buffered 16-bit hex word onto a 4-digit multiplexed display.
// Outputs registered: an/seg/dp/frame_done follow the slot position by one cycle.
// One pending buffer: load_ready drops once a word is held, rises after the frame-boundary commit.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_scan_driver_if.slave    ld,
    input  logic                 lzb,
    output logic [6:0]           seg,
    output logic                 dp,
    output logic [3:0]           an,
    output logic                 frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int DW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DW-1:0]           digit_q, digit_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d, pend_q, pend_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
    logic                    pend_full_q, pend_full_d;
    logic [6:0]              seg_q, seg_d;
    logic [3:0]              an_q, an_d;
    logic                    dp_q, dp_d;
    logic                    frame_done_q, frame_done_d;

    logic                    boundary;
    logic                    lz_blank;
    logic                    slot_blank;
    logic [3:0]              nib_cur;
    logic [6:0]              seg_dec;

    assign boundary      = (digit_q == DIG_LAST) && (cnt_q == CNT_LAST);
    assign ld.load_ready = ~pend_full_q;
    assign nib_cur       = disp_q[{digit_q, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .nib_i (nib_cur),
        .seg_o (seg_dec)
    );

    // Slot counter, digit pointer, and the pending/display double buffer.
    always_comb begin
        cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        digit_d     = (cnt_q == CNT_LAST) ? digit_q + 1'b1 : digit_q;
        disp_d      = disp_q;
        disp_dp_d   = disp_dp_q;
        pend_d      = pend_q;
        pend_dp_d   = pend_dp_q;
        pend_full_d = pend_full_q;
        if (boundary && pend_full_q) begin
            // Commit only between frames so a digit never shows a half-updated word.
            disp_d      = pend_q;
            disp_dp_d   = pend_dp_q;
            pend_full_d = 1'b0;
        end else if (ld.load_valid && !pend_full_q) begin
            pend_d      = ld.load_data;
            pend_dp_d   = ld.load_dp;
            pend_full_d = 1'b1;
        end
    end

    // Leading-zero blanking: this digit and every more-significant digit are zero.
    always_comb begin
        lz_blank = lzb && (digit_q != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((DW'(i) >= digit_q) && (disp_q[4*i +: 4] != 4'h0)) begin
                lz_blank = 1'b0;
            end
        end
    end

    // Next values of the registered display outputs for the current slot position.
    always_comb begin
        slot_blank   = (cnt_q < BLANK_END) || lz_blank;
        an_d         = slot_blank ? AN_OFF : ~(4'b0001 << digit_q);
        seg_d        = slot_blank ? SEG_BLANK : seg_dec;
        dp_d         = slot_blank ? 1'b1 : ~disp_dp_q[digit_q];
        frame_done_d = boundary;
    end

    // Scan and buffer state; reset drops any pending word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            digit_q     <= '0;
            disp_q      <= '0;
            disp_dp_q   <= '0;
            pend_q      <= '0;
            pend_dp_q   <= '0;
            pend_full_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            digit_q     <= digit_d;
            disp_q      <= disp_d;
            disp_dp_q   <= disp_dp_d;
            pend_q      <= pend_d;
            pend_dp_q   <= pend_dp_d;
            pend_full_q <= pend_full_d;
        end
    end

    // Output registers, all dark while in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Downstream display stage of the processor top: consumes the 16-bit result word the core produces and drives the 4-digit multiplexed seven-segment display (segment and anode buses). It time-multiplexes the four hex digits with a refresh counter, inserts an anti-ghosting blank window between digits, and double-buffers new values so the display only updates on frame boundaries. Loads use a valid/ready handshake from the core side.

Parameters:
REFRESH_DIV, 1024, clock cycles per digit slot (must be >= 2)
BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off (must be < REFRESH_DIV)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
load_data  in  16  hex word to display; nibble 0 maps to digit 0 (rightmost)
load_dp  in  4  decimal-point enables per digit, captured with load_data
load_valid  in  1  core offers load_data/load_dp
load_ready  out  1  pending buffer empty; transfer occurs when valid && ready
lzb  in  1  leading-zero blanking enable (live, not captured)
seg  out  7  {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low
an  out  4  digit anodes, active-low, one-hot-low or all-ones
frame_done  out  1  one-cycle pulse at end of digit 3 slot

Behaviour:
- Reset (rst_n low at a clk edge): cnt=0, digit=0, display reg=0, display dp=0, pending empty; an=4'hF, seg=7'h7F, dp=1, load_ready=1, frame_done=0. Reset mid-operation discards any pending value.
- Slot counter cnt: 0..REFRESH_DIV-1, wraps to 0; on wrap digit advances 0->1->2->3->0.
- frame_done=1 for the one cycle when digit==3 && cnt==REFRESH_DIV-1 (registered, asserted the cycle after that state).
- Handshake: valid && ready captures load_data/load_dp into pending, pending becomes full, load_ready=0 from the next cycle. While full, load_valid is ignored.
- Commit: at the frame boundary (digit==3 && cnt==REFRESH_DIV-1), if pending is full, the display reg takes the pending value and pending empties; load_ready=1 the next cycle. A load accepted in the boundary cycle itself is not committed until the next boundary.
- Output generation is registered. an/seg/dp reflect the cnt/digit of the previous cycle (1-cycle latency).
- Blank window: cnt < BLANK_CYCLES -> an=4'hF, seg=7'h7F, dp=1. Otherwise an = ~(1<<digit), seg = decode(nibble[digit]), dp = ~dp_bit[digit].
- Leading-zero blank: if lzb=1 and every nibble from digit up to nibble 3 is 0 and digit!=0, the slot behaves as blank (an=4'hF). Digit 0 is always shown.
- Decode (active-low hex): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.

Decomposition:
- Package seg7_pkg: NUM_DIGITS=4, SEG_BLANK=7'h7F, AN_OFF=4'hF, 16-entry decode constant table.
- One sub-module: hex_to_seg7 (4-bit nibble -> 7-bit active-low pattern, combinational).

Test Plan:
(All tests use REFRESH_DIV=8, BLANK_CYCLES=2.)
- Reset: rst_n low for 3 cycles -> an=F, seg=7F, dp=1, load_ready=1, frame_done=0. After release, the first non-blank slot drives an=1110 with seg=40 (value 0).
- Load 0x1234, dp=0001, mid-frame -> load_ready=0 next cycle. The display stays at 0 until the frame_done pulse. Next frame: digit0 an=1110 seg=19 dp=0; digit1 an=1101 seg=30; digit2 an=1011 seg=24; digit3 an=0111 seg=79. load_ready returns to 1.
- Blank timing: each slot shows an=F for exactly 2 cycles, then one-hot-low for 6 cycles. frame_done pulses once every 32 cycles.
- lzb=1 with value 0x0045 -> digits 3 and 2 show an=F for the full slot, digit1 shows seg=19, digit0 shows seg=12. With value 0x0000, only digit0 lights, seg=40.
- Back-to-back: load 0xAAAA, then hold load_valid with 0xBBBB -> 0xBBBB is not accepted until load_ready rises after the boundary. Frame N+1 shows AAAA (seg=08); frame N+2 shows BBBB (seg=03).
- Reset mid-frame with pending 0xFFFF -> after reset the display shows 0, load_ready=1, and 0xFFFF never appears.
